risci_scoreboard: RTL and testbench

Parametrised register-lock scoreboard for the risci pipeline, successor to the single-set/single-clear lock bitmap. It tracks a saturating count of outstanding writes per architectural register, so several in-flight producers may target the same register. It accepts multiple writeback clears per cycle. The decode stage sees one combinational stall verdict for an instruction with up to NRD sources and one destination.

---
 rtl/risci_pkg.sv | 21 ++
 rtl/risci_scoreboard_entry.sv | 67 ++++++
 rtl/risci_scoreboard.sv | 146 ++++++++++++++
 tb/tb_risci_scoreboard.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risci_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | risci_pkg                                                                  |
// | Shared register-file constants and types for the risci pipeline.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package risci_pkg;

    localparam int c_XN   = 64;
    localparam int c_XWDT = 6;

    typedef logic [c_XWDT-1:0] reg_idx_t;
    typedef logic [c_XN-1:0]   reg_mask_t;

    // Bits needed to hold a count in 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/risci_scoreboard_entry.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | risci_scoreboard_entry                                                     |
// | Per-register saturating up/down count of outstanding writes.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module risci_scoreboard_entry
    import risci_pkg::*;
#(
    parameter int CNTW = 2,
    parameter int DECW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            inc,
    input  logic [DECW-1:0] dec,
    output logic [CNTW-1:0] count,
    output logic            underflow,
    output logic            overflow
);

    localparam int c_EW = ((CNTW + 1) > DECW) ? (CNTW + 1) : DECW;
    localparam logic [c_EW-1:0] c_MAX = c_EW'((1 << CNTW) - 1);

    logic [CNTW-1:0] r_count;
    logic [CNTW-1:0] w_next;
    logic [c_EW-1:0] w_up;
    logic [c_EW-1:0] w_dec;
    logic [c_EW-1:0] w_res;

    // Net the increment against all clears at extended width before clamping.
    always_comb begin
        w_up      = c_EW'(r_count) + c_EW'(inc);
        w_dec     = c_EW'(dec);
        w_res     = '0;
        w_next    = r_count;
        underflow = 1'b0;
        overflow  = 1'b0;
        if (flush) begin
            w_next = '0;
        end else if (w_dec > w_up) begin
            underflow = 1'b1;
            w_next    = '0;
        end else begin
            w_res = w_up - w_dec;
            if (w_res > c_MAX) begin
                overflow = 1'b1;
                w_next   = c_MAX[CNTW-1:0];
            end else begin
                w_next = w_res[CNTW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/risci_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | risci_scoreboard                                                           |
// | Counting register-lock scoreboard: multi-source stall verdict, multi-port  |
// | writeback clear. Define RISCI_SCOREBOARD_FWD_EN to let same-cycle clears   |
// | release waiting sources combinationally.                                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module risci_scoreboard
    import risci_pkg::*;
#(
    parameter int XN   = c_XN,
    parameter int XWDT = c_XWDT,
    parameter int NRD  = 3,
    parameter int NWB  = 2,
    parameter int CNTW = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                issue_valid,
    input  logic [NRD*XWDT-1:0] issue_rs,
    input  logic [NRD-1:0]      issue_rs_en,
    input  logic [XWDT-1:0]     issue_rd,
    input  logic                issue_rd_en,
    output logic                stall,
    output logic                issue_fire,
    input  logic [NWB-1:0]      clr_valid,
    input  logic [NWB*XWDT-1:0] clr_rd,
    output logic [XN-1:0]       busy,
    output logic                err_underflow,
    output logic                err_overflow
);

    localparam int c_DECW = cnt_width(NWB);
    localparam int c_EW   = (CNTW > c_DECW) ? CNTW : c_DECW;
    localparam logic [CNTW-1:0] c_CNT_MAX = CNTW'((1 << CNTW) - 1);

    logic [CNTW-1:0]   w_count [XN];
    logic [CNTW-1:0]   w_eff   [XN];
    logic [c_DECW-1:0] w_dec   [XN];
    logic [XN-1:0]     w_set;
    logic [XN-1:0]     w_uf;
    logic [XN-1:0]     w_of;
    logic              w_src_haz;
    logic              w_dst_haz;
    logic              w_stall;
    logic              w_fire;
    logic              r_err_uf;
    logic              r_err_of;

    // Number of writeback ports releasing each register this cycle.
    always_comb begin
        for (int r = 0; r < XN; r++) begin
            w_dec[r] = '0;
        end
        for (int r = 1; r < XN; r++) begin
            for (int k = 0; k < NWB; k++) begin
                if (clr_valid[k] && (clr_rd[k*XWDT +: XWDT] == XWDT'(r))) begin
                    w_dec[r] = w_dec[r] + c_DECW'(1);
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < XN; r++) begin
`ifdef RISCI_SCOREBOARD_FWD_EN
            if (c_EW'(w_dec[r]) >= c_EW'(w_count[r])) begin
                w_eff[r] = '0;
            end else begin
                w_eff[r] = CNTW'(c_EW'(w_count[r]) - c_EW'(w_dec[r]));
            end
`else
            w_eff[r] = w_count[r];
`endif
        end
    end

    always_comb begin
        w_src_haz = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            if (issue_rs_en[i] && (issue_rs[i*XWDT +: XWDT] != '0) &&
                (w_eff[issue_rs[i*XWDT +: XWDT]] != '0)) begin
                w_src_haz = 1'b1;
            end
        end
        // Saturated destination back-pressures rather than overflowing.
        w_dst_haz = issue_rd_en && (issue_rd != '0) && (w_eff[issue_rd] == c_CNT_MAX);
        w_stall   = issue_valid && (flush || w_src_haz || w_dst_haz);
        w_fire    = issue_valid && !w_stall;
    end

    always_comb begin
        w_set = '0;
        for (int r = 1; r < XN; r++) begin
            w_set[r] = w_fire && issue_rd_en && (issue_rd == XWDT'(r));
        end
    end

    generate
        for (genvar r = 0; r < XN; r++) begin : g_entry
            if (r == 0) begin : g_zero
                assign w_count[r] = '0;
                assign w_uf[r]    = 1'b0;
                assign w_of[r]    = 1'b0;
            end else begin : g_cnt
                risci_scoreboard_entry #(
                    .CNTW (CNTW),
                    .DECW (c_DECW)
                ) u_entry (
                    .clk       (clk),
                    .rst       (rst),
                    .flush     (flush),
                    .inc       (w_set[r]),
                    .dec       (w_dec[r]),
                    .count     (w_count[r]),
                    .underflow (w_uf[r]),
                    .overflow  (w_of[r])
                );
            end
            assign busy[r] = (w_count[r] != '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_uf <= 1'b0;
            r_err_of <= 1'b0;
        end else begin
            if (|w_uf) begin
                r_err_uf <= 1'b1;
            end
            if (|w_of) begin
                r_err_of <= 1'b1;
            end
        end
    end

    assign stall         = w_stall;
    assign issue_fire    = w_fire;
    assign err_underflow = r_err_uf;
    assign err_overflow  = r_err_of;

endmodule
`default_nettype wire

// File: tb/tb_risci_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_risci_scoreboard                                                        |
// | Queue-based self-checking bench for risci_scoreboard.                      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_risci_scoreboard;

    localparam int XN   = 64;
    localparam int XWDT = 6;
    localparam int NRD  = 3;
    localparam int NWB  = 2;
    localparam int CNTW = 2;

    localparam int c_STALL = 0;
    localparam int c_FIRE  = 1;
    localparam int c_BUSY  = 2;
    localparam int c_UF    = 3;
    localparam int c_OF    = 4;

`ifdef RISCI_SCOREBOARD_FWD_EN
    localparam logic c_FWD = 1'b1;
`else
    localparam logic c_FWD = 1'b0;
`endif

    typedef struct {
        int          sel;
        string       tag;
        logic [63:0] exp;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic                issue_valid;
    logic [NRD*XWDT-1:0] issue_rs;
    logic [NRD-1:0]      issue_rs_en;
    logic [XWDT-1:0]     issue_rd;
    logic                issue_rd_en;
    logic                stall;
    logic                issue_fire;
    logic [NWB-1:0]      clr_valid;
    logic [NWB*XWDT-1:0] clr_rd;
    logic [XN-1:0]       busy;
    logic                err_underflow;
    logic                err_overflow;

    exp_t q[$];
    int   r_checks = 0;
    int   r_fails  = 0;

    risci_scoreboard #(
        .XN   (XN),
        .XWDT (XWDT),
        .NRD  (NRD),
        .NWB  (NWB),
        .CNTW (CNTW)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_rs      (issue_rs),
        .issue_rs_en   (issue_rs_en),
        .issue_rd      (issue_rd),
        .issue_rd_en   (issue_rd_en),
        .stall         (stall),
        .issue_fire    (issue_fire),
        .clr_valid     (clr_valid),
        .clr_rd        (clr_rd),
        .busy          (busy),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            c_STALL: return {63'd0, stall};
            c_FIRE:  return {63'd0, issue_fire};
            c_BUSY:  return busy;
            c_UF:    return {63'd0, err_underflow};
            default: return {63'd0, err_overflow};
        endcase
    endfunction

    function automatic logic [63:0] bitm(input int r);
        logic [63:0] m;
        m = 64'd1;
        return m << r;
    endfunction

    task automatic push(input int sel, input string tag, input logic [63:0] v);
        exp_t e;
        e.sel = sel;
        e.tag = tag;
        e.exp = v;
        q.push_back(e);
    endtask

    // Compare everything queued for this cycle mid-period, then advance one edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        while (q.size() > 0) begin
            e = q.pop_front();
            check_value(e.tag, observe(e.sel), e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_rs    = '0;
        issue_rs_en = '0;
        issue_rd    = '0;
        issue_rd_en = 1'b0;
        clr_valid   = '0;
        clr_rd      = '0;
    endtask

    task automatic issue(input int rd, input logic rd_en, input int rs0, input logic rs0_en);
        issue_valid       = 1'b1;
        issue_rd          = XWDT'(rd);
        issue_rd_en       = rd_en;
        issue_rs          = '0;
        issue_rs_en       = '0;
        issue_rs[XWDT-1:0] = XWDT'(rs0);
        issue_rs_en[0]    = rs0_en;
    endtask

    task automatic clear(input int port, input int rd);
        clr_valid[port]              = 1'b1;
        clr_rd[port*XWDT +: XWDT]    = XWDT'(rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(c_STALL, "rst_stall", 0);
        push(c_FIRE,  "rst_fire",  0);
        push(c_BUSY,  "rst_busy",  0);
        push(c_UF,    "rst_uf",    0);
        push(c_OF,    "rst_of",    0);
        tick();

        // Lock r5, then a dependent source stalls until the clear.
        issue(5, 1'b1, 0, 1'b0);
        push(c_STALL, "r5_set_stall", 0);
        push(c_FIRE,  "r5_set_fire",  1);
        tick();
        issue(0, 1'b0, 5, 1'b1);
        push(c_BUSY,  "r5_busy",     bitm(5));
        push(c_STALL, "r5_dep_stall", 1);
        push(c_FIRE,  "r5_dep_fire",  0);
        tick();
        clear(0, 5);
        push(c_STALL, "r5_clr_stall", {63'd0, !c_FWD});
        push(c_BUSY,  "r5_clr_busy",  bitm(5));
        tick();
        idle();
        issue(0, 1'b0, 5, 1'b1);
        push(c_BUSY,  "r5_free_busy",  0);
        push(c_STALL, "r5_free_stall", 0);
        push(c_FIRE,  "r5_free_fire",  1);
        tick();
        idle();

        // Two outstanding writes to r7 need two clears.
        issue(7, 1'b1, 0, 1'b0);
        push(c_FIRE, "r7_a_fire", 1);
        tick();
        push(c_FIRE, "r7_b_fire", 1);
        tick();
        idle();
        clear(0, 7);
        push(c_BUSY, "r7_cnt2_busy", bitm(7));
        tick();
        idle();
        issue(0, 1'b0, 7, 1'b1);
        push(c_BUSY,  "r7_cnt1_busy",  bitm(7));
        push(c_STALL, "r7_cnt1_stall", 1);
        tick();
        clear(1, 7);
        push(c_STALL, "r7_last_clr_stall", {63'd0, !c_FWD});
        tick();
        idle();
        push(c_BUSY, "r7_free_busy", 0);
        tick();

        // r9 at count 2: set plus two clears nets to 1.
        issue(9, 1'b1, 0, 1'b0);
        tick();
        push(c_FIRE, "r9_b_fire", 1);
        tick();
        clear(0, 9);
        clear(1, 9);
        push(c_FIRE, "r9_net_fire", 1);
        push(c_BUSY, "r9_cnt2_busy", bitm(9));
        tick();
        idle();
        push(c_BUSY, "r9_net_busy", bitm(9));
        push(c_UF,   "r9_net_uf",   0);
        tick();
        clear(0, 9);
        tick();
        idle();
        push(c_BUSY, "r9_free_busy", 0);
        tick();

        // Clear of an idle register is an underflow and sticks.
        clear(1, 3);
        push(c_UF, "uf_before", 0);
        tick();
        idle();
        push(c_UF,   "uf_set",  1);
        push(c_BUSY, "uf_busy", 0);
        tick();
        push(c_UF, "uf_sticky", 1);
        tick();

        // Saturation back-pressure at count 3.
        issue(4, 1'b1, 0, 1'b0);
        push(c_FIRE, "r4_1_fire", 1);
        tick();
        push(c_FIRE, "r4_2_fire", 1);
        tick();
        push(c_FIRE, "r4_3_fire", 1);
        tick();
        push(c_BUSY,  "r4_sat_busy",  bitm(4));
        push(c_STALL, "r4_sat_stall", 1);
        push(c_FIRE,  "r4_sat_fire",  0);
        tick();
        idle();
        push(c_BUSY, "r4_hold_busy", bitm(4));
        push(c_OF,   "r4_of",        0);
        tick();

        // Flush squashes the issuing instruction and every lock.
        for (int r = 1; r <= 3; r++) begin
            issue(r, 1'b1, 0, 1'b0);
            tick();
        end
        issue(6, 1'b1, 0, 1'b0);
        flush = 1'b1;
        push(c_STALL, "flush_stall", 1);
        push(c_FIRE,  "flush_fire",  0);
        push(c_BUSY,  "flush_pre_busy", bitm(1) | bitm(2) | bitm(3) | bitm(4));
        tick();
        idle();
        push(c_BUSY, "flush_busy", 0);
        push(c_UF,   "flush_uf_kept", 1);
        tick();

        // Register 0 is never locked and its clears are ignored.
        issue(0, 1'b1, 0, 1'b1);
        clear(0, 0);
        push(c_FIRE, "r0_fire", 1);
        tick();
        idle();
        push(c_BUSY, "r0_busy", 0);
        tick();

        // Reset mid-stream wins over an issuing instruction.
        issue(10, 1'b1, 0, 1'b0);
        tick();
        issue(11, 1'b1, 0, 1'b0);
        rst = 1'b1;
        push(c_BUSY, "prerst_busy", bitm(10));
        tick();
        rst = 1'b0;
        idle();
        push(c_BUSY,  "midrst_busy",  0);
        push(c_UF,    "midrst_uf",    0);
        push(c_OF,    "midrst_of",    0);
        push(c_STALL, "midrst_stall", 0);
        push(c_FIRE,  "midrst_fire",  0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", r_checks, r_fails);
        $finish;
    end

endmodule
`default_nettype wire
